// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU rectangle pipeline: field codes, phases and geometry.
package gpu_pkg;

    typedef enum logic [2:0] {
        WAIT_FOR_START = 3'd0,
        READ_X         = 3'd1,
        READ_WIDTH     = 3'd2,
        READ_Y         = 3'd3,
        READ_HEIGHT    = 3'd4,
        READ_COLOR     = 3'd5
    } field_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        GAP   = 3'd2,
        SWEEP = 3'd3,
        DRAIN = 3'd4
    } phase_t;

    localparam int RECTS_PER_BATCH      = 16;
    localparam int BATCHES              = 4;
    localparam int FIELDS_PER_RECT      = 5;
    localparam int DEFAULT_SCREEN_WIDTH  = 640;
    localparam int DEFAULT_SCREEN_HEIGHT = 480;
    localparam int DRAIN_CYCLES         = 3;

    // Word offset of a field inside one 5-word rectangle record.
    function automatic logic [2:0] field_offset(input field_t f);
        case (f)
            READ_X:      return 3'd0;
            READ_WIDTH:  return 3'd1;
            READ_Y:      return 3'd2;
            READ_HEIGHT: return 3'd3;
            READ_COLOR:  return 3'd4;
            default:     return 3'd0;
        endcase
    endfunction

    function automatic field_t next_field(input field_t f);
        case (f)
            READ_X:      return READ_WIDTH;
            READ_WIDTH:  return READ_Y;
            READ_Y:      return READ_HEIGHT;
            READ_HEIGHT: return READ_COLOR;
            default:     return READ_X;
        endcase
    endfunction

endpackage

// File: rtl/gpu_rect_addr_gen.sv
// Main-memory word address of one rectangle field: base + rect_index*5 + field offset.
module gpu_rect_addr_gen
    import gpu_pkg::*;
#(
    parameter int BASE_ADDR  = 0,
    parameter int ADDR_WIDTH = 13
) (
    input  logic [1:0]            batch,
    input  logic [3:0]            rect,
    input  field_t                field,
    output logic [ADDR_WIDTH-1:0] addr
);

    logic [9:0] base10;
    logic [9:0] index;
    logic [9:0] sum;

    // Arithmetic is deliberately 10 bits wide and wraps; the result is zero-extended.
    assign base10 = 10'(BASE_ADDR);
    assign index  = {4'd0, batch, rect};
    assign sum    = base10 + index * 10'd5 + {7'd0, field_offset(field)};
    assign addr   = ADDR_WIDTH'(sum);

endmodule

// File: rtl/gpu_batch_sequencer.sv
// Per-frame master sequencer: walks 4 batches x 16 rects x 5 fields, each field as LOAD/GAP/SWEEP.
//
// phase | meaning
// IDLE  | waiting for start, all outputs 0 (done pulses here for one cycle)
// LOAD  | 16 reads of one field for the batch, rect_counter 0..15
// GAP   | GAP_CYCLES pipeline settle, last address and rect 15 held
// SWEEP | coord_generator 0..N-1, batch_completed high
// DRAIN | 3 flush cycles after the final COLOR sweep, state held at COLOR
module gpu_batch_sequencer
    import gpu_pkg::*;
#(
    parameter int BASE_ADDR     = 0,
    parameter int ADDR_WIDTH    = 13,
    parameter int SCREEN_WIDTH  = DEFAULT_SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = DEFAULT_SCREEN_HEIGHT,
    parameter int GAP_CYCLES    = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_re,
    output logic [2:0]            state,
    output logic [9:0]            coord_generator,
    output logic [3:0]            rect_counter,
    output logic [1:0]            batch_counter,
    output logic                  batch_completed
);

    phase_t phase, phase_nxt;
    field_t field, field_nxt;
    logic [1:0] batch_nxt;
    logic [3:0] rect_nxt;
    logic [9:0] coord_nxt;
    logic [7:0] timer, timer_nxt;
    logic [9:0] sweep_last;
    logic       done_nxt;
    logic       busy_nxt;
    logic       mem_re_nxt;
    logic       batch_completed_nxt;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;

    assign state = field;

    // Address is generated from the next-cycle indices so mem_addr lands registered with them.
    gpu_rect_addr_gen #(
        .BASE_ADDR  (BASE_ADDR),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_addr_gen (
        .batch (batch_nxt),
        .rect  (rect_nxt),
        .field (field_nxt),
        .addr  (gen_addr)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            phase           <= IDLE;
            field           <= WAIT_FOR_START;
            batch_counter   <= '0;
            rect_counter    <= '0;
            coord_generator <= '0;
            timer           <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            mem_re          <= 1'b0;
            mem_addr        <= '0;
            batch_completed <= 1'b0;
        end else begin
            phase           <= phase_nxt;
            field           <= field_nxt;
            batch_counter   <= batch_nxt;
            rect_counter    <= rect_nxt;
            coord_generator <= coord_nxt;
            timer           <= timer_nxt;
            busy            <= busy_nxt;
            done            <= done_nxt;
            mem_re          <= mem_re_nxt;
            mem_addr        <= mem_addr_nxt;
            batch_completed <= batch_completed_nxt;
        end
    end

    always_comb begin
        case (field)
            READ_X, READ_WIDTH:  sweep_last = 10'(SCREEN_WIDTH - 1);
            READ_Y, READ_HEIGHT: sweep_last = 10'(SCREEN_HEIGHT - 1);
            default:             sweep_last = 10'(RECTS_PER_BATCH - 1);
        endcase
    end

    always_comb begin
        phase_nxt = phase;
        field_nxt = field;
        batch_nxt = batch_counter;
        rect_nxt  = rect_counter;
        coord_nxt = coord_generator;
        timer_nxt = timer;
        done_nxt  = 1'b0;
        case (phase)
            IDLE: begin
                field_nxt = WAIT_FOR_START;
                batch_nxt = '0;
                rect_nxt  = '0;
                coord_nxt = '0;
                // The done cycle is itself IDLE, so a start coinciding with it is refused here.
                if (start && !done) begin
                    phase_nxt = LOAD;
                    field_nxt = READ_X;
                end
            end
            LOAD: begin
                if (rect_counter == 4'(RECTS_PER_BATCH - 1)) begin
                    phase_nxt = GAP;
                    timer_nxt = 8'(GAP_CYCLES - 1);
                end else begin
                    rect_nxt = rect_counter + 4'd1;
                end
            end
            GAP: begin
                if (timer == 8'd0) begin
                    phase_nxt = SWEEP;
                    rect_nxt  = '0;
                    coord_nxt = '0;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            SWEEP: begin
                if (coord_generator == sweep_last) begin
                    coord_nxt = '0;
                    if (field == READ_COLOR) begin
                        if (batch_counter == 2'(BATCHES - 1)) begin
                            phase_nxt = DRAIN;
                            timer_nxt = 8'(DRAIN_CYCLES - 1);
                        end else begin
                            phase_nxt = LOAD;
                            field_nxt = READ_X;
                            batch_nxt = batch_counter + 2'd1;
                        end
                    end else begin
                        phase_nxt = LOAD;
                        field_nxt = next_field(field);
                    end
                end else begin
                    coord_nxt = coord_generator + 10'd1;
                end
            end
            DRAIN: begin
                coord_nxt = '0;
                rect_nxt  = '0;
                if (timer == 8'd0) begin
                    phase_nxt = IDLE;
                    field_nxt = WAIT_FOR_START;
                    batch_nxt = '0;
                    done_nxt  = 1'b1;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            default: begin
                phase_nxt = IDLE;
                field_nxt = WAIT_FOR_START;
            end
        endcase
    end

    always_comb begin
        busy_nxt            = (phase_nxt != IDLE);
        mem_re_nxt          = (phase_nxt == LOAD) || (phase_nxt == GAP);
        batch_completed_nxt = (phase_nxt == SWEEP);
        mem_addr_nxt        = mem_re_nxt ? gen_addr : '0;
    end

endmodule

// File: tb/tb_gpu_batch_sequencer.sv
// Bench for gpu_batch_sequencer: frames with random timing compared cycle by cycle against a frame-schedule model.
module tb_gpu_batch_sequencer;

    localparam int GAPC  = 3;
    localparam int DRN   = 3;
    localparam int SW    = 640;
    localparam int SH    = 480;
    localparam int BASE  = 0;
    localparam int FRAME = 4 * (2 * (16 + GAPC + SW) + 2 * (16 + GAPC + SH) + (16 + GAPC + 16));

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        mem_re;
        logic        bc;
        logic [2:0]  state;
        logic [1:0]  batch;
        logic [3:0]  rect;
        logic [9:0]  coord;
        logic [12:0] addr;
    } out_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, mem_re, batch_completed;
    logic [12:0] mem_addr;
    logic [2:0]  state;
    logic [9:0]  coord_generator;
    logic [3:0]  rect_counter;
    logic [1:0]  batch_counter;

    int n_checks = 0;
    int n_fail   = 0;

    gpu_batch_sequencer #(
        .BASE_ADDR     (BASE),
        .ADDR_WIDTH    (13),
        .SCREEN_WIDTH  (SW),
        .SCREEN_HEIGHT (SH),
        .GAP_CYCLES    (GAPC)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .mem_addr        (mem_addr),
        .mem_re          (mem_re),
        .state           (state),
        .coord_generator (coord_generator),
        .rect_counter    (rect_counter),
        .batch_counter   (batch_counter),
        .batch_completed (batch_completed)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic out_t observe();
        out_t o;
        o.busy   = busy;
        o.done   = done;
        o.mem_re = mem_re;
        o.bc     = batch_completed;
        o.state  = state;
        o.batch  = batch_counter;
        o.rect   = rect_counter;
        o.coord  = coord_generator;
        o.addr   = mem_addr;
        return o;
    endfunction

    // Expected outputs k cycles after the first LOAD cycle, derived from the frame schedule.
    // m marks which fields are defined at that point.
    task automatic model(input int k, output out_t e, output out_t m);
        int rem;
        int n;
        int seg;
        e = '0;
        m = '1;
        rem = k;
        if (k >= FRAME + DRN) begin
            e.done = (k == FRAME + DRN);
            return;
        end
        if (k >= FRAME) begin
            e.busy  = 1'b1;
            e.state = 3'd5;
            m.batch = '0;
            m.rect  = '0;
            m.addr  = '0;
            return;
        end
        for (int b = 0; b < 4; b++) begin
            for (int f = 1; f <= 5; f++) begin
                n   = (f <= 2) ? SW : ((f <= 4) ? SH : 16);
                seg = 16 + GAPC + n;
                if (rem < seg) begin
                    e.busy  = 1'b1;
                    e.state = 3'(f);
                    e.batch = 2'(b);
                    if (rem < 16 + GAPC) begin
                        e.rect   = (rem < 16) ? 4'(rem) : 4'd15;
                        e.mem_re = 1'b1;
                        e.addr   = 13'((BASE + (b * 16 + int'(e.rect)) * 5 + f - 1) % 1024);
                    end else begin
                        e.bc    = 1'b1;
                        e.coord = 10'(rem - 16 - GAPC);
                        m.addr  = '0;
                    end
                    return;
                end
                rem -= seg;
            end
        end
    endtask

    task automatic check_out(input string tag, input int k, input out_t obs, input out_t exp, input out_t msk);
        n_checks++;
        assert ((obs & msk) === (exp & msk)) else begin
            n_fail++;
            $error("FAIL %s k=%0d observed=%h required=%h", tag, k, obs & msk, exp & msk);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
        end
    endtask

    // One frame from a start pulse; abort_at >= 0 applies reset after that cycle's check.
    task automatic run_frame(input string tag, input int abort_at, input bit noisy);
        out_t e, m, o;
        int n_done;
        int done_at;
        n_done  = 0;
        done_at = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k <= FRAME + DRN + 5; k++) begin
            model(k, e, m);
            o = observe();
            check_out(tag, k, o, e, m);
            if (o.done) begin
                n_done++;
                done_at = k;
            end
            if (k == abort_at) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
                check_out("abort_reset", k + 1, observe(), '0, '1);
                for (int i = 0; i < 10; i++) begin
                    step();
                    o = observe();
                    if (o.done) n_done++;
                    check_out("post_abort_idle", i, o, '0, '1);
                end
                check_int("abort_done_count", n_done, 0);
                return;
            end
            if (k == FRAME + DRN) start = 1'b1;
            else if (noisy && k < FRAME + DRN) start = ($urandom_range(0, 3) == 0);
            else start = 1'b0;
            step();
        end
        start = 1'b0;
        check_int({tag, "_done_count"}, n_done, 1);
        check_int({tag, "_done_cycle"}, done_at, FRAME + DRN);
    endtask

    initial begin
        int abort_at;
        reset = 1'b1;
        start = 1'b0;
        repeat (3) step();
        check_out("reset_state", 0, observe(), '0, '1);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check_out("idle", i, observe(), '0, '1);
        end

        run_frame("frame_quiet", -1, 1'b0);

        repeat ($urandom_range(1, 8)) step();
        run_frame("frame_noisy", -1, 1'b1);

        repeat ($urandom_range(1, 8)) step();
        // Batch 1 HEIGHT sweep spans cycles 4187..4666 of the frame.
        abort_at = 4187 + int'($urandom_range(0, 479));
        run_frame("frame_abort", abort_at, 1'b1);

        repeat ($urandom_range(1, 8)) step();
        run_frame("frame_after_abort", -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gpu_batch_sequencer.md
Name: gpu_batch_sequencer

Overview:
- Master sequencer that drives gpu_receiver_fsm once per frame.
- Walks 64 rectangles in 4 batches of 16. For each batch it processes the fields X, WIDTH, Y, HEIGHT, COLOR in that order.
- Each field has three phases: a 16-word LOAD from main rect memory, a 3-cycle GAP for pipeline settling, then a SWEEP of coordinates.
- Emits the state, coord_generator, rect_counter, batch_counter and batch_completed sideband that the receiver consumes, plus the main-memory read address.

Parameters:
- BASE_ADDR, 0, word address of rect 0 field X in main memory.
- ADDR_WIDTH, 13, main-memory address width.
- SCREEN_WIDTH, 640, X/WIDTH sweep length.
- SCREEN_HEIGHT, 480, Y/HEIGHT sweep length.
- GAP_CYCLES, 3, cycles between LOAD and SWEEP; must equal the receiver pipeline depth.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins a frame when idle
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at frame end
- mem_addr  out  ADDR_WIDTH  main-memory read address
- mem_re  out  1  read enable
- state  out  3  field code: 0 WAIT, 1 X, 2 WIDTH, 3 Y, 4 HEIGHT, 5 COLOR
- coord_generator  out  10  sweep coordinate
- rect_counter  out  4  rect index within the batch
- batch_counter  out  2  batch index
- batch_completed  out  1  0 during LOAD/GAP, 1 during SWEEP

Behaviour:
- Reset: all outputs are 0 and the phase is IDLE. Reset mid-frame aborts immediately, with no done pulse.
- Phases: IDLE → LOAD → GAP → SWEEP → (next field LOAD | DRAIN) → IDLE.
- IDLE:
  - state=0; mem_re=0.
  - start=1 → LOAD with field X, batch 0, busy=1 from the next cycle.
  - start while busy is ignored.
- LOAD (16 cycles):
  - rect_counter counts 0..15.
  - mem_re=1; batch_completed=0; coord_generator=0.
  - mem_addr = BASE_ADDR + (batch_counter*16 + rect_counter)*5 + field_offset, where field_offset is X0 W1 Y2 H3 C4. Use 10-bit unsigned arithmetic, zero-extended to ADDR_WIDTH.
  - Main-memory data must reach the receiver din exactly 3 cycles after mem_addr (system requirement).
- GAP (GAP_CYCLES):
  - rect_counter holds 15; mem_addr holds the last LOAD address; mem_re=1.
  - The redundant buffer rewrites are therefore idempotent.
- SWEEP:
  - batch_completed=1; mem_re=0; rect_counter=0.
  - coord_generator counts 0..N-1, with N = SCREEN_WIDTH for X/WIDTH, SCREEN_HEIGHT for Y/HEIGHT, and 16 for COLOR.
  - On the last coordinate the next cycle advances the field.
- Field advance:
  - X→WIDTH→Y→HEIGHT→COLOR.
  - After COLOR, batch_counter increments and the field returns to X.
  - After COLOR of batch 3 → DRAIN.
- DRAIN (3 cycles):
  - state held at 5 (COLOR); batch_completed=0; mem_re=0.
  - coord_generator=0 so the receiver flushes.
  - Then done=1 for one cycle, busy=0, state=0, IDLE.
- A start pulse coinciding with done is ignored.
- Frame length: 4 × (2×(16+3+640) + 2×(16+3+480) + (16+3+16)) = 9404 cycles from the first LOAD cycle to the last SWEEP cycle. done follows 3 DRAIN cycles later.
- All outputs are registered; no combinational input→output paths.

Decomposition:
- Shared package gpu_pkg:
  - Field codes: WAIT_FOR_START, READ_X, READ_WIDTH, READ_Y, READ_HEIGHT, READ_COLOR.
  - RECTS_PER_BATCH=16, BATCHES=4, FIELDS_PER_RECT=5.
  - Screen-size constants.
  - The phase enum (IDLE, LOAD, GAP, SWEEP, DRAIN).
- gpu_receiver_fsm is switched to import the field codes from gpu_pkg.
- One natural sub-module: gpu_rect_addr_gen, the combinational base + index×5 + offset calculation.

Test Plan:
- Reset then idle 20 cycles → all outputs 0, busy=0, no done.
- start pulse, BASE_ADDR=0 → first 16 cycles: mem_addr 0,5,10,…,75, state=1, batch_completed=0. The 3 GAP cycles hold mem_addr=75. SWEEP then runs coord 0..639 with batch_completed=1.
- Full frame → done exactly once, 9404+3 cycles after the first LOAD cycle. Batch 2 COLOR LOAD addresses are 164,169,…,239 (rects 32..47 ×5 + 4).
- start asserted repeatedly during busy and on the done cycle → no restart, frame length unchanged, exactly one done.
- reset asserted during batch 1 HEIGHT SWEEP → next cycle all outputs 0, no done. A subsequent start produces a normal frame.
- Scoreboard check with gpu_receiver_fsm attached → the receiver finish pulse occurs during the final COLOR SWEEP + DRAIN window, and the sequencer done follows it.
